// File: rtl/op_stream_checker_pkg.sv
// op_stream_checker_pkg: shared state, phase encodings and default width for the op-sequence checker.
package op_stream_checker_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE, WAIT_ZERO, WAIT_SEED, TRACK} state_t;
  localparam logic [1:0] PH_NEG_A = 2'd0;
  localparam logic [1:0] PH_AND = 2'd1;
  localparam logic [1:0] PH_NEG_R = 2'd2;
  localparam logic [1:0] PH_ADD = 2'd3;
endpackage

// File: rtl/op_seq_predict.sv
// op_seq_predict: one step of the generator update rule, (phase, seed, register) -> next output.
module op_seq_predict
  import op_stream_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [1:0]       phase,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] y
);
  always_comb
    y = phase == PH_NEG_A ? -a :
        phase == PH_AND   ? a & m :
        phase == PH_NEG_R ? -m : a + m;
endmodule

// File: rtl/op_stream_checker.sv
// op_stream_checker: recovers the seed from a generator stream and flags samples that break the sequence.
module op_stream_checker
  import op_stream_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] seed,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count
);
  state_t state, state_n;
  logic [1:0] phase, phase_n;
  logic [WIDTH-1:0] m, m_n, seed_n, exp_n;
  logic mis_n;
  logic [ERR_W-1:0] err_n;
  // Prediction is taken from the next-state model so `expected` is registered alongside it.
  op_seq_predict #(.WIDTH(WIDTH)) u_pred (.phase(phase_n), .a(seed_n), .m(m_n), .y(exp_n));
  assign locked = state == TRACK;
  always_comb begin
    state_n = state;
    phase_n = phase;
    m_n = m;
    seed_n = seed;
    mis_n = 1'b0;
    err_n = err_count;
    if (sync) begin
      state_n = WAIT_ZERO;
      err_n = '0;
    end else if (in_valid) begin
      case (state)
        WAIT_ZERO: begin
          state_n = in_data == '0 ? WAIT_SEED : WAIT_ZERO;
          mis_n = in_data != '0;
        end
        WAIT_SEED: begin
          seed_n = -in_data;
          m_n = in_data;
          phase_n = PH_AND;
          state_n = TRACK;
        end
        TRACK: begin
          mis_n = in_data != expected;
          m_n = expected;
          phase_n = phase + 2'd1;
        end
        default: ;
      endcase
      if (mis_n && !(&err_count)) err_n = err_count + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      phase <= PH_NEG_A;
      m <= '0;
      seed <= '0;
      expected <= '0;
      mismatch <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      m <= m_n;
      seed <= seed_n;
      expected <= exp_n;
      mismatch <= mis_n;
      err_count <= err_n;
    end
endmodule

// File: doc/op_stream_checker.md
Name: op_stream_checker

Overview:
- Receive-side counterpart of the 4-phase operation-sequence generator (load seed A; output register cycles -A, A&R, -R, A+R).
- Consumes the generator's 32-bit output stream and recovers seed A from the first post-load samples.
- Then runs its own copy of the generator's update rule to predict every following sample, and flags and counts mismatches.
- Sits at the link or bench boundary as the generator's receiver and self-checker.

Parameters:
WIDTH, 32, data width of the stream and seed
ERR_W, 16, width of the saturating error counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
sync  input  1  pulse aligned with the generator's load; restarts acquisition
in_valid  input  1  in_data is a valid stream sample this cycle
in_data  input  WIDTH  generator output sample
seed  output  WIDTH  recovered seed A
locked  output  1  high while in TRACK
expected  output  WIDTH  prediction for the next sample (valid when locked)
mismatch  output  1  one-cycle pulse, sample differed from expectation
err_count  output  ERR_W  saturating mismatch count since last reset or sync

Behaviour:
- Reset values: seed=0, locked=0, expected=0, mismatch=0, err_count=0, state=IDLE, phase=0, model m=0.
- States: IDLE, WAIT_ZERO, WAIT_SEED, TRACK.
- IDLE: ignores in_valid and waits for sync.
- Any state, on sync=1: go to WAIT_ZERO, clear err_count, clear locked. sync takes priority over a simultaneous in_valid; that sample is dropped.
- WAIT_ZERO, valid sample: 0 -> WAIT_SEED. Nonzero -> mismatch pulse, err_count+1, remain in WAIT_ZERO.
- WAIT_SEED, valid sample s: seed <= -s (two's complement, mod 2^WIDTH), m <= s, phase <= 1, go to TRACK, locked <= 1.
- TRACK, expected value as a function of phase using seed A and model m:
  - phase 0: -A
  - phase 1: A & m
  - phase 2: -m
  - phase 3: A + m (wraps mod 2^WIDTH, carry discarded)
- TRACK, valid sample: compare in_data against the expected value. Then m <= expected, not in_data, so the model stays aligned after a corrupted sample. Phase increments mod 4 (3 wraps to 0).
- Output `expected` is registered and always shows the prediction for the next valid sample.
- Latency: mismatch asserts in the cycle after the offending sample is accepted, for exactly one cycle.
- err_count saturates at 2^ERR_W-1 and never wraps.
- in_valid=0: all state holds (phase, m and err_count frozen).
- A=0 is legal: the stream is all zeros and is never a mismatch.
- reset asserted mid-operation: all outputs take their reset values on the next edge, regardless of sync or in_valid.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WAIT_ZERO, WAIT_SEED, TRACK)
  - 2-bit phase constants PH_NEG_A=0, PH_AND=1, PH_NEG_R=2, PH_ADD=3
  - default WIDTH
- One sub-module, op_seq_predict: purely combinational (phase, A, m) -> next expected value. Parameterised by WIDTH. The generator model and the checker can share it.

Test Plan:
- Clean lock, A=12: reset, sync, then stream 0, FFFFFFF4, 4, FFFFFFFC, 8, FFFFFFF4, 4.
  - Required: seed=0000000C and locked after the 2nd sample.
  - Required: no mismatch, err_count=0.
- Corrupted sample: as above, but send 5 instead of 4 at the third sample.
  - Required: mismatch pulse one cycle later, err_count=1.
  - Required: the following FFFFFFFC and 8 are accepted without error, since the model does not follow corruption.
- Bad zero: sync, then samples 7, 0, FFFFFFFF.
  - Required: one mismatch, state WAIT_ZERO then TRACK, seed=00000001.
  - Required: next expected = 1 & FFFFFFFF = 00000001.
- Gaps and priority:
  - Insert in_valid=0 cycles between samples: expected, phase and err_count hold.
  - Assert sync together with in_valid: sample dropped, state WAIT_ZERO, err_count=0.
- Saturation and reset: ERR_W=2, feed 5 wrong samples in TRACK -> err_count stays 3. Then assert reset mid-stream -> all outputs 0, state IDLE, samples ignored until sync.
- Edge seeds:
  - A=80000000: stream 0, 80000000, 80000000, 80000000, 0 -> no mismatch (phase-3 add wraps).
  - A=0: all-zero stream -> no mismatch.
